axi_decerr_slave: RTL and testbench
===================================

Name: axi_decerr_slave

Overview:
- AXI4 responder placed on the SoC crossbar's default (no-match) port.
- Any request that no address-map rule claims (outside Debug/ROM/CLINT/PLIC/ExtIO/DRAM) is routed here.
- Protocol-correct completion with DECERR for every burst, so a core access to a hole in the memory map traps cleanly instead of hanging the bus.
- Independent read and write channels; at most one outstanding transaction per direction.

Parameters:
- IdWidth, 5, AXI ID width on the slave side; equals master ID width 4 + clog2(2 masters).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- ReadData, 64'hCA11_AB1E_BADC_AB1E, constant returned on RDATA; DataWidth bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- aw_id_i  in  IdWidth  write address ID
- aw_addr_i  in  AddrWidth  write address
- aw_valid_i  in  1  / aw_ready_o  out  1
- w_last_i  in  1  last write beat (W data/strb ignored)
- w_valid_i  in  1  / w_ready_o  out  1
- b_id_o  out  IdWidth  / b_resp_o  out  2  / b_valid_o  out  1  / b_ready_i  in  1
- ar_id_i  in  IdWidth  / ar_addr_i  in  AddrWidth  / ar_len_i  in  8
- ar_valid_i  in  1  / ar_ready_o  out  1
- r_id_o  out  IdWidth  / r_data_o  out  DataWidth  / r_resp_o  out  2
- r_last_o  out  1  / r_valid_o  out  1  / r_ready_i  in  1
- err_valid_o  out  1  sticky: an error has been captured
- err_addr_o  out  AddrWidth  address of first captured error
- err_write_o  out  1  captured error was a write
- err_clear_i  in  1  clears the capture register

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-low on rst_ni; all state updates on the clk_i rising edge.
- Reset values: FSMs in IDLE; b_valid_o=0, r_valid_o=0, r_last_o=0; b_id_o/r_id_o=0; err_* = 0.
- aw_ready_o=1 and ar_ready_o=1 only in their IDLE states, so they are 1 immediately out of reset.
- b_resp_o and r_resp_o are constant 2'b11 (DECERR). r_data_o is constant ReadData.
- Write FSM:
  - W_IDLE: aw_ready_o=1. On AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Each W handshake is consumed. A handshake with w_last_i=1 goes to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=latched ID. On b_ready_i, go to W_IDLE.
  - W beats arriving before AW are stalled (w_ready_o=0 outside W_DATA); AXI permits this.
  - Minimum write latency: AW at cycle N, single beat at N+1, B valid at N+2.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ar_id_i and ar_len_i, clear the 8-bit beat counter, go to R_DATA.
  - R_DATA: r_valid_o=1; r_last_o=(cnt==len). On R handshake, increment cnt. A handshake with r_last_o=1 goes to R_IDLE.
  - Exactly ar_len_i+1 beats are returned. ar_len_i=255 gives 256 beats; the counter never wraps before last.
  - First R beat valid in the cycle after the AR handshake. There is a one-cycle bubble between back-to-back reads.
- Outputs are held stable while valid && !ready, per AXI.
- Read and write channels are fully independent; simultaneous AW and AR are both accepted in the same cycle.
- Reset asserted mid-burst: FSMs return to IDLE, any partial burst is abandoned, outputs go to reset values on the next edge.

Optional Feature:
- Macro: AXI_DECERR_CAPTURE_EN.
- Defined:
  - On the first AW or AR handshake while err_valid_o=0, latch the address into err_addr_o, set err_write_o, set err_valid_o.
  - If AW and AR handshake in the same cycle, the write wins.
  - err_clear_i=1 clears all three fields. Clear has priority over a same-cycle capture.
- Not defined: err_valid_o, err_addr_o and err_write_o are tied 0; err_clear_i is ignored; no capture flops.

Decomposition:
- Shared package: DECERR/OKAY resp constants, the write and read FSM state enums, and the ReadData default. These go in the existing SoC package beside the address map.
- No sub-module: two small FSMs in one file. The optional capture register is inline, guarded by the macro.

Test Plan:
- AW id=5'h13 addr=0x3000_0000, one W beat with last -> B at N+2: b_id=0x13, b_resp=2'b11; aw_ready back to 1 after b_ready.
- AR id=5'h07 len=3 with r_ready held 1 -> 4 beats: r_data=0xCA11AB1EBADCAB1E, resp=2'b11, r_last only on beat 4, r_id=0x07.
- AR len=255 with random r_ready backpressure -> exactly 256 beats, single r_last, outputs stable during stalls.
- AW and AR in the same cycle (write len 2, read len 0) -> both accepted; B and R complete independently with correct IDs.
- Assert rst_ni=0 mid-read at beat 2 of 4 -> next edge r_valid=0 and ar_ready=1; a new AR completes normally.
- With AXI_DECERR_CAPTURE_EN: writes to 0x3000_0008, then reads 0x2_0000_0000 -> err_addr=0x3000_0008, err_write=1; after err_clear, the next read captures 0x2_0000_0000 with err_write=0.

Source files
------------

// File: rtl/axi_decerr_slave_pkg.sv
// Shared definitions for the default-slot DECERR responder: AXI response
// codes, the write/read channel state encodings and the constant read payload.
package axi_decerr_slave_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Pattern returned on every read beat so software sees an obvious marker
    localparam logic [63:0] ReadDataDefault = 64'hCA11_AB1E_BADC_AB1E;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // A read beat is the last one once the beat index reaches the burst length
    function automatic logic beat_is_last(input logic [7:0] cnt, input logic [7:0] len);
        return (cnt == len);
    endfunction

endpackage

// File: rtl/axi_decerr_slave.sv
// AXI4 responder for the crossbar's default port. Every write and read burst
// is completed protocol-correctly with a DECERR response so that accesses to
// unmapped addresses trap instead of hanging the bus. Read and write channels
// run independently with at most one outstanding transaction each.
//
// Optional build feature: define AXI_DECERR_CAPTURE_EN to record the address
// and direction of the first unmapped access in a sticky capture register.
module axi_decerr_slave
    import axi_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] ReadData = DataWidth'(ReadDataDefault)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,

    input  logic                 w_last_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,

    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,

    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,

    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,

    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o,
    input  logic                 err_clear_i
);

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e            w_state_q, w_state_d;
    logic                aw_ready_q, aw_ready_d;
    logic                w_ready_q, w_ready_d;
    logic                b_valid_q, b_valid_d;
    logic [IdWidth-1:0]  b_id_q, b_id_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign aw_hs = aw_valid_i & aw_ready_q;
    assign w_hs  = w_valid_i & w_ready_q;
    assign b_hs  = b_valid_q & b_ready_i;

    // Write FSM next state: accept AW, swallow beats until last, then respond
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d  = W_DATA;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    b_id_d     = aw_id_i;
                end
            end
            W_DATA: begin
                if (w_hs && w_last_i) begin
                    w_state_d = W_RESP;
                    w_ready_d = 1'b0;
                    b_valid_d = 1'b1;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d  = W_IDLE;
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                end
            end
            default: begin
                w_state_d  = W_IDLE;
                aw_ready_d = 1'b1;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
            end
        endcase
    end

    // Write FSM state and registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
        end
    end

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = RespDecerr;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e            r_state_q, r_state_d;
    logic                ar_ready_q, ar_ready_d;
    logic                r_valid_q, r_valid_d;
    logic                r_last_q, r_last_d;
    logic [IdWidth-1:0]  r_id_q, r_id_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [7:0]          r_cnt_q, r_cnt_d;

    logic ar_hs;
    logic r_hs;

    assign ar_hs = ar_valid_i & ar_ready_q;
    assign r_hs  = r_valid_q & r_ready_i;

    // Read FSM next state: accept AR, then stream len+1 beats with last on the final one
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_id_d     = r_id_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d  = R_DATA;
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_id_d     = ar_id_i;
                    r_len_d    = ar_len_i;
                    r_cnt_d    = 8'd0;
                    r_last_d   = beat_is_last(8'd0, ar_len_i);
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        r_state_d  = R_IDLE;
                        ar_ready_d = 1'b1;
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_last_d = beat_is_last(r_cnt_q + 8'd1, r_len_q);
                    end
                end
            end
            default: begin
                r_state_d  = R_IDLE;
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
                r_last_d   = 1'b0;
            end
        endcase
    end

    // Read FSM state, beat counter and registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_len_q    <= 8'd0;
            r_cnt_q    <= 8'd0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_last_o   = r_last_q;
    assign r_id_o     = r_id_q;
    assign r_data_o   = ReadData;
    assign r_resp_o   = RespDecerr;

    // ------------------------------------------------------------------
    // Optional first-error capture register
    // ------------------------------------------------------------------
`ifdef AXI_DECERR_CAPTURE_EN
    logic                 err_valid_q, err_valid_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic                 err_write_q, err_write_d;

    // Capture the first unmapped access; a write beats a same-cycle read and clear beats both
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_write_d = 1'b0;
        end else if (!err_valid_q) begin
            if (aw_hs) begin
                err_valid_d = 1'b1;
                err_addr_d  = aw_addr_i;
                err_write_d = 1'b1;
            end else if (ar_hs) begin
                err_valid_d = 1'b1;
                err_addr_d  = ar_addr_i;
                err_write_d = 1'b0;
            end
        end
    end

    // Capture register storage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_write_o = err_write_q;
`else
    logic unused_capture_inputs;

    assign unused_capture_inputs = ^{aw_addr_i, ar_addr_i, err_clear_i};

    assign err_valid_o = 1'b0;
    assign err_addr_o  = '0;
    assign err_write_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed testbench for the DECERR default slave: reset values, single and
// burst writes, reads with and without backpressure, concurrent channels,
// reset during a burst, and (when AXI_DECERR_CAPTURE_EN is defined) the
// first-error capture register.
module tb_axi_decerr_slave;

    localparam int IdW   = 5;
    localparam int AddrW = 64;
    localparam int DataW = 64;
    localparam logic [63:0] ExpData = 64'hCA11_AB1E_BADC_AB1E;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IdW-1:0]    aw_id;
    logic [AddrW-1:0]  aw_addr;
    logic              aw_valid;
    logic              aw_ready;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;
    logic [IdW-1:0]    b_id;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;
    logic [IdW-1:0]    ar_id;
    logic [AddrW-1:0]  ar_addr;
    logic [7:0]        ar_len;
    logic              ar_valid;
    logic              ar_ready;
    logic [IdW-1:0]    r_id;
    logic [DataW-1:0]  r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;
    logic              err_valid;
    logic [AddrW-1:0]  err_addr;
    logic              err_write;
    logic              err_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_decerr_slave dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .aw_id_i     (aw_id),
        .aw_addr_i   (aw_addr),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .w_last_i    (w_last),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .ar_id_i     (ar_id),
        .ar_addr_i   (ar_addr),
        .ar_len_i    (ar_len),
        .ar_valid_i  (ar_valid),
        .ar_ready_o  (ar_ready),
        .r_id_o      (r_id),
        .r_data_o    (r_data),
        .r_resp_o    (r_resp),
        .r_last_o    (r_last),
        .r_valid_o   (r_valid),
        .r_ready_i   (r_ready),
        .err_valid_o (err_valid),
        .err_addr_o  (err_addr),
        .err_write_o (err_write),
        .err_clear_i (err_clear)
    );

    // Count one comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs set afterwards land mid-cycle
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  beats;
        int  lasts;
        bit  rdy;

        rst_n     = 1'b0;
        aw_id     = '0;
        aw_addr   = '0;
        aw_valid  = 1'b0;
        w_last    = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_id     = '0;
        ar_addr   = '0;
        ar_len    = 8'd0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        err_clear = 1'b0;

        // Reset values
        applyStimulus(2);
        checkOutput("rst_aw_ready", aw_ready, 1);
        checkOutput("rst_ar_ready", ar_ready, 1);
        checkOutput("rst_w_ready", w_ready, 0);
        checkOutput("rst_b_valid", b_valid, 0);
        checkOutput("rst_r_valid", r_valid, 0);
        checkOutput("rst_r_last", r_last, 0);
        checkOutput("rst_b_id", b_id, 0);
        checkOutput("rst_r_id", r_id, 0);
        checkOutput("rst_err_valid", err_valid, 0);
        checkOutput("rst_err_addr", err_addr, 0);
        checkOutput("rst_err_write", err_write, 0);
        checkOutput("b_resp_const", b_resp, 2'b11);
        checkOutput("r_resp_const", r_resp, 2'b11);
        checkOutput("r_data_const", r_data, ExpData);
        rst_n = 1'b1;
        applyStimulus(1);
        checkOutput("post_rst_aw_ready", aw_ready, 1);

        // Single-beat write; a W beat arriving before AW must stall
        w_valid = 1'b1;
        w_last  = 1'b1;
        applyStimulus(1);
        checkOutput("w_early_ready", w_ready, 0);
        checkOutput("w_early_b_valid", b_valid, 0);
        aw_valid = 1'b1;
        aw_id    = 5'h13;
        aw_addr  = 64'h3000_0000;
        applyStimulus(1);
        aw_valid = 1'b0;
        checkOutput("wr_aw_ready_busy", aw_ready, 0);
        checkOutput("wr_w_ready", w_ready, 1);
        checkOutput("wr_b_not_yet", b_valid, 0);
        applyStimulus(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        checkOutput("wr_b_valid", b_valid, 1);
        checkOutput("wr_b_id", b_id, 5'h13);
        checkOutput("wr_b_resp", b_resp, 2'b11);
        checkOutput("wr_w_ready_off", w_ready, 0);
        applyStimulus(1);
        checkOutput("wr_b_hold_valid", b_valid, 1);
        checkOutput("wr_b_hold_id", b_id, 5'h13);
        checkOutput("wr_aw_ready_wait", aw_ready, 0);
        b_ready = 1'b1;
        applyStimulus(1);
        b_ready = 1'b0;
        checkOutput("wr_b_done", b_valid, 0);
        checkOutput("wr_aw_ready_back", aw_ready, 1);

        // Four-beat read with r_ready held high
        ar_valid = 1'b1;
        ar_id    = 5'h07;
        ar_len   = 8'd3;
        ar_addr  = 64'h4000_0000;
        applyStimulus(1);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        checkOutput("rd_ar_ready_busy", ar_ready, 0);
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("rd_valid_%0d", b), r_valid, 1);
            checkOutput($sformatf("rd_last_%0d", b), r_last, (b == 3));
            checkOutput($sformatf("rd_id_%0d", b), r_id, 5'h07);
            checkOutput($sformatf("rd_data_%0d", b), r_data, ExpData);
            checkOutput($sformatf("rd_resp_%0d", b), r_resp, 2'b11);
            applyStimulus(1);
        end
        r_ready = 1'b0;
        checkOutput("rd_done_valid", r_valid, 0);
        checkOutput("rd_done_ar_ready", ar_ready, 1);

        // 256-beat read under random backpressure
        ar_valid = 1'b1;
        ar_id    = 5'h11;
        ar_len   = 8'd255;
        applyStimulus(1);
        ar_valid = 1'b0;
        beats = 0;
        lasts = 0;
        for (int cyc = 0; cyc < 2000 && beats < 256; cyc++) begin
            rdy     = 1'($urandom_range(0, 1));
            r_ready = rdy;
            checkOutput("bp_valid", r_valid, 1);
            checkOutput("bp_last", r_last, (beats == 255));
            checkOutput("bp_id", r_id, 5'h11);
            checkOutput("bp_data", r_data, ExpData);
            if (rdy && r_valid) begin
                beats++;
                if (r_last) lasts++;
            end
            applyStimulus(1);
        end
        r_ready = 1'b0;
        checkOutput("bp_beat_count", beats, 256);
        checkOutput("bp_last_count", lasts, 1);
        checkOutput("bp_done_valid", r_valid, 0);
        checkOutput("bp_done_ar_ready", ar_ready, 1);

        // Simultaneous AW (3 beats) and AR (1 beat)
        aw_valid = 1'b1;
        aw_id    = 5'h0A;
        aw_addr  = 64'h5000_0000;
        ar_valid = 1'b1;
        ar_id    = 5'h15;
        ar_len   = 8'd0;
        applyStimulus(1);
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        checkOutput("dual_aw_taken", aw_ready, 0);
        checkOutput("dual_ar_taken", ar_ready, 0);
        checkOutput("dual_w_ready", w_ready, 1);
        checkOutput("dual_r_valid", r_valid, 1);
        checkOutput("dual_r_last", r_last, 1);
        checkOutput("dual_r_id", r_id, 5'h15);
        w_valid = 1'b1;
        w_last  = 1'b0;
        applyStimulus(2);
        checkOutput("dual_b_mid", b_valid, 0);
        checkOutput("dual_w_ready_mid", w_ready, 1);
        w_last = 1'b1;
        applyStimulus(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        checkOutput("dual_b_valid", b_valid, 1);
        checkOutput("dual_b_id", b_id, 5'h0A);
        checkOutput("dual_r_held", r_valid, 1);
        checkOutput("dual_r_id_held", r_id, 5'h15);
        b_ready = 1'b1;
        r_ready = 1'b1;
        applyStimulus(1);
        b_ready = 1'b0;
        r_ready = 1'b0;
        checkOutput("dual_b_done", b_valid, 0);
        checkOutput("dual_r_done", r_valid, 0);
        checkOutput("dual_aw_idle", aw_ready, 1);
        checkOutput("dual_ar_idle", ar_ready, 1);

        // Reset in the middle of a four-beat read
        ar_valid = 1'b1;
        ar_id    = 5'h03;
        ar_len   = 8'd3;
        applyStimulus(1);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        applyStimulus(2);
        checkOutput("mid_beat2_valid", r_valid, 1);
        checkOutput("mid_beat2_last", r_last, 0);
        rst_n   = 1'b0;
        r_ready = 1'b0;
        applyStimulus(1);
        checkOutput("mid_rst_r_valid", r_valid, 0);
        checkOutput("mid_rst_ar_ready", ar_ready, 1);
        checkOutput("mid_rst_r_id", r_id, 0);
        checkOutput("mid_rst_r_last", r_last, 0);
        rst_n    = 1'b1;
        ar_valid = 1'b1;
        ar_id    = 5'h1C;
        ar_len   = 8'd1;
        applyStimulus(1);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        checkOutput("post_rst_rd_valid0", r_valid, 1);
        checkOutput("post_rst_rd_last0", r_last, 0);
        checkOutput("post_rst_rd_id", r_id, 5'h1C);
        applyStimulus(1);
        checkOutput("post_rst_rd_last1", r_last, 1);
        applyStimulus(1);
        r_ready = 1'b0;
        checkOutput("post_rst_rd_done", r_valid, 0);

`ifdef AXI_DECERR_CAPTURE_EN
        // First-error capture: write then read, clear, read again
        err_clear = 1'b1;
        applyStimulus(1);
        err_clear = 1'b0;
        checkOutput("cap_cleared", err_valid, 0);
        aw_valid = 1'b1;
        aw_id    = 5'h01;
        aw_addr  = 64'h3000_0008;
        applyStimulus(1);
        aw_valid = 1'b0;
        checkOutput("cap_w_valid", err_valid, 1);
        checkOutput("cap_w_addr", err_addr, 64'h3000_0008);
        checkOutput("cap_w_write", err_write, 1);
        w_valid = 1'b1;
        w_last  = 1'b1;
        applyStimulus(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        applyStimulus(1);
        b_ready  = 1'b0;
        ar_valid = 1'b1;
        ar_addr  = 64'h2_0000_0000;
        ar_len   = 8'd0;
        r_ready  = 1'b1;
        applyStimulus(1);
        ar_valid = 1'b0;
        applyStimulus(1);
        r_ready = 1'b0;
        checkOutput("cap_sticky_addr", err_addr, 64'h3000_0008);
        checkOutput("cap_sticky_write", err_write, 1);
        err_clear = 1'b1;
        applyStimulus(1);
        err_clear = 1'b0;
        checkOutput("cap_clr_valid", err_valid, 0);
        checkOutput("cap_clr_addr", err_addr, 0);
        checkOutput("cap_clr_write", err_write, 0);
        ar_valid = 1'b1;
        r_ready  = 1'b1;
        applyStimulus(1);
        ar_valid = 1'b0;
        checkOutput("cap_r_valid", err_valid, 1);
        checkOutput("cap_r_addr", err_addr, 64'h2_0000_0000);
        checkOutput("cap_r_write", err_write, 0);
        applyStimulus(1);
        r_ready = 1'b0;

        // Clear wins over a same-cycle capture
        err_clear = 1'b1;
        applyStimulus(1);
        ar_valid = 1'b1;
        ar_addr  = 64'h7_0000_0000;
        r_ready  = 1'b1;
        applyStimulus(1);
        ar_valid  = 1'b0;
        err_clear = 1'b0;
        checkOutput("cap_clr_prio_valid", err_valid, 0);
        applyStimulus(1);
        r_ready = 1'b0;

        // Write wins over a same-cycle read
        aw_valid = 1'b1;
        aw_addr  = 64'h6000_0010;
        ar_valid = 1'b1;
        ar_addr  = 64'h8_0000_0000;
        applyStimulus(1);
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        checkOutput("cap_both_addr", err_addr, 64'h6000_0010);
        checkOutput("cap_both_write", err_write, 1);
        w_valid = 1'b1;
        w_last  = 1'b1;
        r_ready = 1'b1;
        applyStimulus(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        r_ready = 1'b0;
        b_ready = 1'b1;
        applyStimulus(1);
        b_ready = 1'b0;
`else
        // Without the capture feature the error outputs stay tied low
        err_clear = 1'b1;
        aw_valid  = 1'b1;
        aw_addr   = 64'h3000_0008;
        applyStimulus(1);
        aw_valid  = 1'b0;
        err_clear = 1'b0;
        checkOutput("nocap_valid", err_valid, 0);
        checkOutput("nocap_addr", err_addr, 0);
        checkOutput("nocap_write", err_write, 0);
        w_valid = 1'b1;
        w_last  = 1'b1;
        applyStimulus(1);
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        applyStimulus(1);
        b_ready = 1'b0;
        checkOutput("nocap_valid_after", err_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
